// File: rtl/imem_pkg.sv
// imem_pkg: shared defaults, FSM state type and the parity helper for the
// loadable instruction memory.
package imem_pkg;

  localparam int DEF_IW = 9;
  localparam int DEF_AW = 8;
  localparam logic [8:0] DEF_FILL = 9'b111_111_111;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } imem_state_e;

  // Even parity: the returned bit makes the total count of ones even.
  // Narrower words are zero-extended by the caller, which leaves parity unchanged.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/imem_loadable_if.sv
// imem_loadable_if: load port and fetch port of the loadable instruction memory.
// master = program loader / fetch stage, slave = the memory.
// Optional macro IMEM_PARITY_EN adds par_flip (load side) and par_err (fetch side).
interface imem_loadable_if
  import imem_pkg::*;
#(
  parameter int IW = DEF_IW,
  parameter int AW = DEF_AW
);

  logic          ld_start;
  logic          ld_valid;
  logic [IW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          load_done;
  logic [AW:0]   words_loaded;
  logic          fetch_req;
  logic [AW-1:0] PC;
  logic [IW-1:0] inst;
  logic          inst_valid;
  logic          inst_oob;
`ifdef IMEM_PARITY_EN
  logic          par_flip;
  logic          par_err;

  modport master (
    output ld_start, ld_valid, ld_data, ld_last, par_flip, fetch_req, PC,
    input  ld_ready, load_done, words_loaded, inst, inst_valid, inst_oob, par_err
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, par_flip, fetch_req, PC,
    output ld_ready, load_done, words_loaded, inst, inst_valid, inst_oob, par_err
  );
`else
  modport master (
    output ld_start, ld_valid, ld_data, ld_last, fetch_req, PC,
    input  ld_ready, load_done, words_loaded, inst, inst_valid, inst_oob
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, fetch_req, PC,
    output ld_ready, load_done, words_loaded, inst, inst_valid, inst_oob
  );
`endif

endinterface

// File: rtl/imem_store.sv
// imem_store: instruction array with per-word written bits (and parity bits
// when IMEM_PARITY_EN is defined). One synchronous write port, one synchronous
// read port whose register already carries the FILL substitution.
module imem_store
  import imem_pkg::*;
#(
  parameter int            IW    = DEF_IW,
  parameter int            AW    = DEF_AW,
  parameter int            DEPTH = 256,
  parameter logic [IW-1:0] FILL  = IW'(DEF_FILL)
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          clr_written,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [IW-1:0] wr_data,
`ifdef IMEM_PARITY_EN
  input  logic          wr_par_flip,
  output logic          rd_perr,
`endif
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [IW-1:0] rd_word
);

  localparam int          IXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [IW-1:0]    mem_r [DEPTH];
  logic [DEPTH-1:0] written_r;
  logic [IW-1:0]    rd_word_r;

  logic [IXW-1:0]   wr_idx_s;
  logic [IXW-1:0]   rd_idx_s;
  logic             wr_ok_s;
  logic             rd_in_range_s;
  logic             rd_hit_s;
  logic             rd_good_s;
  logic [IW-1:0]    rd_data_s;

`ifdef IMEM_PARITY_EN
  logic             par_r [DEPTH];
  logic             rd_par_bad_s;
  logic             rd_perr_r;
`endif

  // Address decode: in-range checks and array index for both ports.
  always_comb begin
    wr_idx_s      = wr_addr[IXW-1:0];
    rd_idx_s      = rd_addr[IXW-1:0];
    wr_ok_s       = wr_en && ({1'b0, wr_addr} < DEPTH_C);
    rd_in_range_s = ({1'b0, rd_addr} < DEPTH_C);
    rd_data_s     = mem_r[rd_idx_s];
    if (rd_in_range_s) begin
      rd_hit_s = written_r[rd_idx_s];
    end else begin
      rd_hit_s = 1'b0;
    end
`ifdef IMEM_PARITY_EN
    rd_par_bad_s = rd_hit_s && (even_parity(64'(rd_data_s)) != par_r[rd_idx_s]);
    rd_good_s    = rd_hit_s && !rd_par_bad_s;
`else
    rd_good_s    = rd_hit_s;
`endif
  end

  // Array write port: the data array is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (wr_ok_s) begin
      mem_r[wr_idx_s] <= wr_data;
    end
  end

`ifdef IMEM_PARITY_EN
  // Parity write port: even parity of the beat, optionally inverted for fault injection.
  always_ff @(posedge CLK) begin
    if (wr_ok_s) begin
      par_r[wr_idx_s] <= even_parity(64'(wr_data)) ^ wr_par_flip;
    end
  end
`endif

  // Written bits: cleared by reset or on a (re)load start, set by each stored beat.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      written_r <= {DEPTH{1'b0}};
    end else if (clr_written) begin
      written_r <= {DEPTH{1'b0}};
    end else if (wr_ok_s) begin
      written_r[wr_idx_s] <= 1'b1;
    end
  end

  // Read register: captures the word (or FILL) on a fetch and holds otherwise.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rd_word_r <= FILL;
`ifdef IMEM_PARITY_EN
      rd_perr_r <= 1'b0;
`endif
    end else begin
      if (rd_en) begin
        rd_word_r <= rd_good_s ? rd_data_s : FILL;
      end
`ifdef IMEM_PARITY_EN
      rd_perr_r <= rd_en && rd_par_bad_s;
`endif
    end
  end

  assign rd_word = rd_word_r;
`ifdef IMEM_PARITY_EN
  assign rd_perr = rd_perr_r;
`endif

endmodule

// File: rtl/imem_loadable.sv
// imem_loadable: loadable instruction memory for the 9-bit core.
// After reset it streams a program in through the load port (LOAD), then serves
// registered fetches (RUN). Unwritten and out-of-range words read as FILL.
// Optional macro IMEM_PARITY_EN adds per-word parity with par_flip / par_err.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int            IW    = DEF_IW,
  parameter int            AW    = DEF_AW,
  parameter int            DEPTH = 256,
  parameter logic [IW-1:0] FILL  = IW'(DEF_FILL)
) (
  input logic             CLK,
  input logic             rst_n,
  imem_loadable_if.slave  bus
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  imem_state_e state_r;
  logic [AW:0] ptr_r;
  logic        ld_ready_r;
  logic        load_done_r;
  logic        inst_valid_r;
  logic        inst_oob_r;

  logic        accept_s;
  logic        rd_en_s;
  logic        pc_oob_s;
  logic [AW:0] ptr_inc_s;

  // Handshake decode. Writes only happen in LOAD and reads only in RUN, so the
  // two store ports are never active together. ld_start outranks a same-cycle beat.
  always_comb begin
    accept_s  = (state_r == LOAD) && bus.ld_valid && ld_ready_r && !bus.ld_start;
    rd_en_s   = (state_r == RUN) && bus.fetch_req;
    pc_oob_s  = ({1'b0, bus.PC} >= DEPTH_C);
    ptr_inc_s = ptr_r + (AW+1)'(1);
  end

  // Load/run FSM with load pointer and the registered handshake/fetch flags.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= LOAD;
      ptr_r        <= '0;
      ld_ready_r   <= 1'b0;
      load_done_r  <= 1'b0;
      inst_valid_r <= 1'b0;
      inst_oob_r   <= 1'b0;
    end else begin
      inst_valid_r <= rd_en_s;
      inst_oob_r   <= rd_en_s && pc_oob_s;
      case (state_r)
        LOAD: begin
          load_done_r <= 1'b0;
          if (bus.ld_start) begin
            ptr_r      <= '0;
            ld_ready_r <= 1'b1;
          end else if (accept_s) begin
            ptr_r <= ptr_inc_s;
            if (bus.ld_last || (ptr_inc_s == DEPTH_C)) begin
              state_r     <= RUN;
              ld_ready_r  <= 1'b0;
              load_done_r <= 1'b1;
            end else begin
              ld_ready_r <= 1'b1;
            end
          end else begin
            ld_ready_r <= (ptr_r < DEPTH_C);
          end
        end
        RUN: begin
          if (bus.ld_start) begin
            // A fetch sampled on this edge still reads the old contents.
            state_r     <= LOAD;
            ptr_r       <= '0;
            ld_ready_r  <= 1'b1;
            load_done_r <= 1'b0;
          end else begin
            ld_ready_r  <= 1'b0;
            load_done_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= LOAD;
          ptr_r       <= '0;
          ld_ready_r  <= 1'b0;
          load_done_r <= 1'b0;
        end
      endcase
    end
  end

  imem_store #(
    .IW    (IW),
    .AW    (AW),
    .DEPTH (DEPTH),
    .FILL  (FILL)
  ) u_store (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .clr_written (bus.ld_start),
    .wr_en       (accept_s),
    .wr_addr     (ptr_r[AW-1:0]),
    .wr_data     (bus.ld_data),
`ifdef IMEM_PARITY_EN
    .wr_par_flip (bus.par_flip),
    .rd_perr     (bus.par_err),
`endif
    .rd_en       (rd_en_s),
    .rd_addr     (bus.PC),
    .rd_word     (bus.inst)
  );

  assign bus.ld_ready     = ld_ready_r;
  assign bus.load_done    = load_done_r;
  assign bus.words_loaded = ptr_r;
  assign bus.inst_valid   = inst_valid_r;
  assign bus.inst_oob     = inst_oob_r;

endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: scoreboard bench for imem_loadable (DEPTH=256) plus a
// second DEPTH=16 instance for out-of-range fetches.
module tb_imem_loadable;
  import imem_pkg::*;

  localparam int         IW     = 9;
  localparam int         AW     = 8;
  localparam int         DEPTH  = 256;
  localparam int         DEPTH2 = 16;
  localparam logic [8:0] FILLW  = 9'h1FF;
`ifdef IMEM_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic rst_n;
  always #5 CLK = ~CLK;

  imem_loadable_if #(.IW(IW), .AW(AW)) bus ();
  imem_loadable_if #(.IW(IW), .AW(AW)) bus2 ();

  imem_loadable #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .FILL(FILLW)) dut (
    .CLK(CLK), .rst_n(rst_n), .bus(bus)
  );

  imem_loadable #(.IW(IW), .AW(AW), .DEPTH(DEPTH2), .FILL(FILLW)) dut2 (
    .CLK(CLK), .rst_n(rst_n), .bus(bus2)
  );

  typedef struct packed {
    logic [8:0] inst;
    logic       oob;
    logic       perr;
  } exp_t;

  exp_t       sb [$];
  logic [8:0] mdl  [DEPTH];
  bit         wr_m [DEPTH];
  bit         bad_m[DEPTH];
  int         ptr_m;
  bit         run_m;
  int         errors = 0;
  int         checks = 0;

  function automatic logic [8:0] model_word(input int pc);
    if (pc >= DEPTH || !wr_m[pc] || bad_m[pc]) return FILLW;
    return mdl[pc];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      wr_m[i]  = 1'b0;
      bad_m[i] = 1'b0;
    end
    ptr_m = 0;
  endtask

  task automatic edge1();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard cycle: one clock; a fetch pushed before the edge must appear after it.
  task automatic sb_tick();
    bit   exp_v;
    exp_t e;
    exp_v = (sb.size() > 0);
    edge1();
    bus.fetch_req = 1'b0;
    checks++;
    if (bus.inst_valid !== exp_v) begin
      errors++;
      $display("FAIL inst_valid: got %b expected %b", bus.inst_valid, exp_v);
    end
    if (exp_v) begin
      e = sb.pop_front();
      checks++;
      if (bus.inst !== e.inst) begin
        errors++;
        $display("FAIL inst: got %h expected %h", bus.inst, e.inst);
      end
      checks++;
      if (bus.inst_oob !== e.oob) begin
        errors++;
        $display("FAIL inst_oob: got %b expected %b", bus.inst_oob, e.oob);
      end
`ifdef IMEM_PARITY_EN
      checks++;
      if (bus.par_err !== e.perr) begin
        errors++;
        $display("FAIL par_err: got %b expected %b", bus.par_err, e.perr);
      end
`endif
    end
  endtask

  task automatic issue_fetch(input int pc);
    exp_t e;
    bus.fetch_req = 1'b1;
    bus.PC        = 8'(pc);
    if (run_m) begin
      e.inst = model_word(pc);
      e.oob  = 1'b0;
      e.perr = wr_m[pc] && bad_m[pc];
      sb.push_back(e);
    end
  endtask

  task automatic load_beat(input logic [8:0] d, input bit last, input bit flip);
    int guard = 0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
`ifdef IMEM_PARITY_EN
    bus.par_flip = flip;
`endif
    while (bus.ld_ready !== 1'b1 && guard < 20) begin
      sb_tick();
      guard++;
    end
    if (bus.ld_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ld_ready_wait: got %b expected 1 within 20 cycles", bus.ld_ready);
    end else begin
      mdl[ptr_m]   = d;
      wr_m[ptr_m]  = 1'b1;
      bad_m[ptr_m] = flip & PARITY_ON;
      ptr_m++;
      sb_tick();
      if (last || ptr_m == DEPTH) run_m = 1'b1;
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
`ifdef IMEM_PARITY_EN
    bus.par_flip = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks += 6;
    if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_ready: got %b expected 0", bus.ld_ready); end
    if (bus.load_done !== 1'b0) begin errors++; $display("FAIL rst_load_done: got %b expected 0", bus.load_done); end
    if (bus.inst !== FILLW) begin errors++; $display("FAIL rst_inst: got %h expected %h", bus.inst, FILLW); end
    if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b expected 0", bus.inst_valid); end
    if (bus.inst_oob !== 1'b0) begin errors++; $display("FAIL rst_inst_oob: got %b expected 0", bus.inst_oob); end
    if (bus.words_loaded !== 9'd0) begin errors++; $display("FAIL rst_words: got %0d expected 0", bus.words_loaded); end
    @(negedge CLK);
    rst_n = 1'b1;
    model_clear();
    run_m = 1'b0;
    edge1();
    checks++;
    if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ld_ready: got %b expected 1", bus.ld_ready); end
  endtask

  task automatic test_load_and_fetch();
    logic [8:0] w [4];
    w[0] = 9'b100_000110;
    w[1] = 9'b001_001_001;
    w[2] = 9'b001_101_001;
    w[3] = 9'b011_0_101_11;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) issue_fetch(0);
      load_beat(w[i], (i == 3), 1'b0);
      if (i == 2) begin
        checks++;
        if (bus.load_done !== 1'b0) begin errors++; $display("FAIL load_done_early: got %b expected 0", bus.load_done); end
      end
    end
    checks += 3;
    if (bus.load_done !== 1'b1) begin errors++; $display("FAIL load_done: got %b expected 1", bus.load_done); end
    if (bus.words_loaded !== 9'd4) begin errors++; $display("FAIL words_loaded: got %0d expected 4", bus.words_loaded); end
    if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL run_ld_ready: got %b expected 0", bus.ld_ready); end
    for (int pc = 0; pc < 4; pc++) begin
      issue_fetch(pc);
      sb_tick();
    end
    issue_fetch(4);
    sb_tick();
    issue_fetch(255);
    sb_tick();
    issue_fetch(3);
    sb_tick();
    sb_tick();
    checks++;
    if (bus.inst !== w[3]) begin errors++; $display("FAIL inst_hold: got %h expected %h", bus.inst, w[3]); end
  endtask

  task automatic test_oob_depth16();
    int         pcs [4];
    logic [8:0] exp_i;
    logic       exp_o;
    pcs[0] = 200; pcs[1] = 16; pcs[2] = 15; pcs[3] = 0;
    bus2.ld_valid = 1'b1;
    bus2.ld_data  = 9'h0AA;
    bus2.ld_last  = 1'b1;
    edge1();
    bus2.ld_valid = 1'b0;
    bus2.ld_last  = 1'b0;
    checks += 2;
    if (bus2.load_done !== 1'b1) begin errors++; $display("FAIL d16_load_done: got %b expected 1", bus2.load_done); end
    if (bus2.words_loaded !== 9'd1) begin errors++; $display("FAIL d16_words: got %0d expected 1", bus2.words_loaded); end
    for (int k = 0; k < 4; k++) begin
      exp_i = (pcs[k] == 0) ? 9'h0AA : FILLW;
      exp_o = (pcs[k] >= DEPTH2);
      bus2.fetch_req = 1'b1;
      bus2.PC        = 8'(pcs[k]);
      edge1();
      bus2.fetch_req = 1'b0;
      checks += 3;
      if (bus2.inst_valid !== 1'b1) begin errors++; $display("FAIL d16_valid pc=%0d: got %b expected 1", pcs[k], bus2.inst_valid); end
      if (bus2.inst !== exp_i) begin errors++; $display("FAIL d16_inst pc=%0d: got %h expected %h", pcs[k], bus2.inst, exp_i); end
      if (bus2.inst_oob !== exp_o) begin errors++; $display("FAIL d16_oob pc=%0d: got %b expected %b", pcs[k], bus2.inst_oob, exp_o); end
    end
  endtask

  task automatic test_start_with_fetch();
    issue_fetch(1);
    bus.ld_start = 1'b1;
    sb_tick();
    bus.ld_start = 1'b0;
    run_m = 1'b0;
    model_clear();
    checks += 3;
    if (bus.load_done !== 1'b0) begin errors++; $display("FAIL restart_load_done: got %b expected 0", bus.load_done); end
    if (bus.words_loaded !== 9'd0) begin errors++; $display("FAIL restart_words: got %0d expected 0", bus.words_loaded); end
    if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL restart_ld_ready: got %b expected 1", bus.ld_ready); end
    issue_fetch(1);
    sb_tick();
    load_beat(9'h155, 1'b1, 1'b0);
    issue_fetch(1);
    sb_tick();
    issue_fetch(0);
    sb_tick();
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    bus.ld_start = 1'b1;
    sb_tick();
    bus.ld_start = 1'b0;
    run_m = 1'b0;
    model_clear();
    load_beat(9'h106, 1'b0, 1'b0);
    load_beat(9'h049, 1'b0, 1'b0);
    load_beat(9'h069, 1'b1, 1'b1);
    issue_fetch(2);
    sb_tick();
    issue_fetch(0);
    sb_tick();
    issue_fetch(1);
    sb_tick();
    issue_fetch(5);
    sb_tick();
  endtask
`endif

  task automatic test_full_load();
    bus.ld_start = 1'b1;
    sb_tick();
    bus.ld_start = 1'b0;
    run_m = 1'b0;
    model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      load_beat(9'($urandom_range(0, 510)), 1'b0, 1'b0);
      if (i == DEPTH - 2) begin
        checks += 2;
        if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL full_ready_255: got %b expected 1", bus.ld_ready); end
        if (bus.load_done !== 1'b0) begin errors++; $display("FAIL full_done_255: got %b expected 0", bus.load_done); end
      end
    end
    checks += 3;
    if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", bus.ld_ready); end
    if (bus.load_done !== 1'b1) begin errors++; $display("FAIL full_done: got %b expected 1", bus.load_done); end
    if (bus.words_loaded !== 9'h100) begin errors++; $display("FAIL full_words: got %0d expected 256", bus.words_loaded); end
    bus.ld_valid = 1'b1;
    bus.ld_data  = 9'h000;
    sb_tick();
    bus.ld_valid = 1'b0;
    checks++;
    if (bus.words_loaded !== 9'h100) begin errors++; $display("FAIL dropped_beat_words: got %0d expected 256", bus.words_loaded); end
    issue_fetch(0);
    sb_tick();
    issue_fetch(255);
    sb_tick();
    for (int k = 0; k < 4; k++) begin
      issue_fetch($urandom_range(0, 255));
      sb_tick();
    end
    issue_fetch(128);
    sb_tick();
  endtask

  task automatic test_reset_mid_load();
    bus.ld_start = 1'b1;
    sb_tick();
    bus.ld_start = 1'b0;
    run_m = 1'b0;
    model_clear();
    load_beat(9'h011, 1'b0, 1'b0);
    load_beat(9'h022, 1'b0, 1'b0);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 9'h0FF;
    #3;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (bus.words_loaded !== 9'd0) begin errors++; $display("FAIL midrst_words: got %0d expected 0", bus.words_loaded); end
    if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL midrst_ld_ready: got %b expected 0", bus.ld_ready); end
    if (bus.load_done !== 1'b0) begin errors++; $display("FAIL midrst_load_done: got %b expected 0", bus.load_done); end
    if (bus.inst !== FILLW) begin errors++; $display("FAIL midrst_inst: got %h expected %h", bus.inst, FILLW); end
    if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", bus.inst_valid); end
    bus.ld_valid = 1'b0;
    sb.delete();
    model_clear();
    run_m = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    edge1();
    load_beat(9'h033, 1'b1, 1'b0);
    issue_fetch(1);
    sb_tick();
    issue_fetch(0);
    sb_tick();
  endtask

  initial begin
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = 9'h000; bus.ld_last = 1'b0;
    bus.fetch_req = 1'b0; bus.PC = 8'h00;
    bus2.ld_start = 1'b0; bus2.ld_valid = 1'b0; bus2.ld_data = 9'h000; bus2.ld_last = 1'b0;
    bus2.fetch_req = 1'b0; bus2.PC = 8'h00;
`ifdef IMEM_PARITY_EN
    bus.par_flip = 1'b0;
    bus2.par_flip = 1'b0;
`endif
    run_m = 1'b0;
    ptr_m = 0;
    test_reset();
    test_load_and_fetch();
    test_oob_depth16();
    test_start_with_fetch();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    test_full_load();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised, clocked successor to the fixed-ROM instruction memory.
- Program contents are streamed in through a load port after reset. The core then fetches through a registered, request/valid read port.
- Locations that were never written, and out-of-range PCs, return the halt/fill word.
- Sits between the program loader (testbench or host) and the fetch stage of the 9-bit core.

Parameters:
- IW, 9, instruction width in bits.
- AW, 8, PC/address width.
- DEPTH, 256, number of instruction words; must be ≤ 2**AW.
- FILL, 9'b111_111_111, word returned for unwritten or out-of-range locations.

Ports:
- CLK  input  1  single clock; everything is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- ld_start  input  1  pulse; starts a (re)load from address 0.
- ld_valid  input  1  load beat valid.
- ld_data  input  IW  instruction word to store.
- ld_last  input  1  marks the final beat of a load.
- ld_ready  output  1  block accepts a load beat this cycle.
- load_done  output  1  high while in RUN.
- words_loaded  output  AW+1  count of beats accepted in the current load.
- fetch_req  input  1  fetch request.
- PC  input  AW  fetch address, sampled with fetch_req.
- inst  output  IW  fetched instruction.
- inst_valid  output  1  one-cycle pulse; inst is valid.
- inst_oob  output  1  qualifies inst_valid; PC ≥ DEPTH.

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD, load pointer=0, words_loaded=0, all per-word written bits cleared.
  - inst=FILL, inst_valid=0, inst_oob=0, ld_ready=0, load_done=0.
  - The array data itself is not reset.
  - Reset mid-load or mid-fetch discards everything in flight.
- State LOAD:
  - ld_ready=1 iff pointer<DEPTH.
  - A beat is accepted when ld_valid&&ld_ready. It writes ld_data at the pointer, sets that word's written bit, and increments the pointer and words_loaded.
  - Accepted beat with ld_last=1 → RUN next cycle.
  - Pointer reaching DEPTH → RUN next cycle, with or without ld_last.
  - fetch_req is ignored (inst_valid stays 0). ld_start in LOAD restarts at pointer 0 and clears the written bits.
- State RUN:
  - ld_ready=0, load_done=1.
  - fetch_req=1 at edge N → at edge N+1: inst_valid=1 and inst=array[PC] if PC<DEPTH and that word is written, else FILL. inst_oob=(PC≥DEPTH).
  - No request → inst_valid=0 and inst holds its last value. Back-to-back requests give one result per cycle.
  - ld_start → LOAD next cycle: pointer=0, words_loaded=0, written bits cleared.
  - ld_start together with fetch_req: the fetch completes from the old contents, then the block enters LOAD.
- Load beats presented outside LOAD are dropped silently.
- One write port and one read port; a read and a write are never active in the same cycle.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each stored word carries an even-parity bit computed at write time.
  - Extra input par_flip (1 bit) inverts the stored parity bit for the beat it accompanies; this is for test only.
  - Extra output par_err (1 bit) pulses with inst_valid when a written, in-range word fails its parity check. In that case inst is forced to FILL.
  - Unwritten or out-of-range words never flag par_err.
- Undefined: no parity storage, and neither par_flip nor par_err exists.

Decomposition:
- Package imem_pkg holds:
  - Default IW, AW and FILL constants.
  - State enum {LOAD, RUN}.
  - Parity helper function.
- One sub-module, imem_store: the storage array plus written bits (plus parity bits when enabled), with one synchronous write port, one synchronous read port, and a clear-written input.
- Top level keeps the FSM, the pointer and the fetch output registers.

Test Plan:
- Reset, then load 4 beats {9'b100_000110, 9'b001_001_001, 9'b001_101_001, 9'b011_0_101_11} with ld_last on beat 4 → load_done=1 one cycle after beat 4; words_loaded=4.
- Fetch PC=0..3 back-to-back → inst_valid for 4 consecutive cycles, one cycle after each request, returning the loaded words in order.
- Fetch PC=4 (unwritten) → inst=9'h1FF, inst_oob=0. With DEPTH=16, fetch PC=200 → inst=9'h1FF, inst_oob=1.
- Fetch during LOAD → no inst_valid. Stream 256 beats without ld_last → ld_ready drops after beat 256, then the block enters RUN.
- In RUN, pulse ld_start together with fetch PC=1 → inst=9'b001_001_001. Then in LOAD, fetch PC=1 → inst_valid=0; after reload of 1 beat, PC=1 → 9'h1FF. Assert rst_n low mid-load → outputs at reset values immediately.
- With IMEM_PARITY_EN, load PC=2 with par_flip=1 → fetching PC=2 gives par_err=1 and inst=9'h1FF. Fetching PC=0 gives par_err=0.
